uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side sequencer for the UART RX path. It consumes the glitch-filtered serial line from the RX input filter and the oversampling tick RXC. It detects and validates start bits, samples each bit at mid-bit, assembles LSB-first data, and checks the stop bit. Completed characters go to the host side through a valid/ready handshake, with framing and overrun status.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 16, RXC ticks per bit period (even, ≥4)
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- RXC  input  1  oversampling tick, one-CLK-cycle pulse, OVERSAMPLE per bit
- RXD  input  1  filtered serial line (idle high)
- DATA_READY  input  1  consumer accepts DATA_OUT when high with DATA_VALID
- DATA_OUT  output  DATA_BITS  received character, bit 0 = first data bit
- DATA_VALID  output  1  DATA_OUT holds an unconsumed character
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
- OVERRUN  output  1  one-cycle pulse: character dropped, DATA_VALID was busy
- BUSY  output  1  high in any state other than IDLE/WAIT_HIGH

## Operation
- States: WAIT_HIGH, IDLE, START, DATA, STOP (PARITY with RX_PARITY_EN).
- Tick counter cnt: width $clog2(OVERSAMPLE), advances only on RXC. Bit index bidx: 0..DATA_BITS-1.
- WAIT_HIGH: on RXC with RXD=1 → IDLE. This state guards against a line stuck low.
- IDLE: on RXC with RXD=0 → START, cnt=0.
- START: each RXC increments cnt. On the tick where cnt==OVERSAMPLE/2-1 (mid start bit), sample RXD:
  - 1 → IDLE (false start, no flags)
  - 0 → DATA, cnt=0, bidx=0
- DATA: on the tick where cnt==OVERSAMPLE-1, shift RXD into bit bidx and set cnt=0.
  - After bit DATA_BITS-1 → STOP (or PARITY).
  - Otherwise cnt increments per tick.
- STOP: on the tick where cnt==OVERSAMPLE-1, sample RXD:
  - 1 → deliver character, go to IDLE
  - 0 → FRAME_ERR pulse, character discarded, go to WAIT_HIGH
- Deliver:
  - If DATA_VALID=0, or DATA_VALID=1 with DATA_READY=1 in the same cycle: DATA_OUT←shift register, DATA_VALID=1, no OVERRUN.
  - Otherwise the new character is dropped, DATA_OUT is unchanged, and OVERRUN pulses.
- Handshake: the transfer occurs on a CLK edge with DATA_VALID&DATA_READY. DATA_VALID clears the next cycle unless a delivery happens on the same edge. DATA_READY while DATA_VALID=0 has no effect.
- RXD is ignored between sample points. RXC pulses are counted only while in START/DATA/STOP/PARITY.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State→WAIT_HIGH; cnt, bidx and the shift register are cleared.
  - All outputs are 0: DATA_OUT=0, DATA_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - A reset mid-frame aborts the frame with no flags.
- Samples are registered on the CLK edge where RXC=1 and the cnt condition holds.
- DATA_VALID, FRAME_ERR and OVERRUN assert on the first CLK edge after the stop-bit sample edge, i.e. one CLK of latency.
- Pulses last exactly one CLK.
- A start edge arriving on the same tick as the return to IDLE is not seen until the next RXC.
- Frame sampling: the start bit is sampled OVERSAMPLE/2 ticks after the detect tick. Each data bit, the parity bit and the stop bit are then sampled every OVERSAMPLE ticks.

## Configuration
- Macro RX_PARITY_EN.
- Defined:
  - Adds input PARITY_ODD (1 = odd parity, 0 = even) and output PARITY_ERR (1-cycle pulse).
  - Adds a PARITY state after DATA, with one bit period sampled like a data bit.
  - Mismatch between the sampled bit and the XOR of data bits (inverted if PARITY_ODD): at STOP, a valid stop bit gives a PARITY_ERR pulse with the character discarded and no DATA_VALID.
  - FRAME_ERR takes precedence when both errors occur.
- Undefined: no PARITY state or parity ports; the frame is start + DATA_BITS + stop.

## Test plan
- Frame 0xA5, stop=1, DATA_READY=1 → DATA_OUT=0xA5, DATA_VALID high 1 CLK after the stop sample, then low next cycle.
- RXD low for 4 ticks after idle, then high → no DATA_VALID and no flags; BUSY returns to 0; a following 0x3C frame is received correctly.
- Frame 0x3C with stop=0 → FRAME_ERR one-cycle pulse, no DATA_VALID. With the line held low, a second frame is ignored until RXD goes high for a tick.
- DATA_READY=0 across frames 0x11 then 0x22 → DATA_OUT stays 0x11, OVERRUN pulses once. DATA_READY=1 on the 0x33 delivery cycle → DATA_OUT=0x33, no OVERRUN.
- Assert RST at bit 4 of a 0xFF frame → all outputs 0 immediately, state WAIT_HIGH. The next full frame 0x5A is received correctly.
- With RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 → DATA_OUT=0x07. With parity bit 0 → PARITY_ERR pulse, no DATA_VALID.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling, LSB-first assembly,
// stop-bit check and valid/ready delivery. Optional parity stage under macro RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXC,
    input  logic                 RXD,
    input  logic                 DATA_READY,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
`ifdef RX_PARITY_EN
    ,
    input  logic                 PARITY_ODD,
    output logic                 PARITY_ERR
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] MID_TICK = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] END_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
`ifdef RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [BW-1:0]        bidx_reg, bidx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    // One-cycle flags raised on the stop-sample edge; outputs follow one CLK later.
    logic                 deliver_reg, deliver_next;
    logic                 frame_pend_reg, frame_pend_next;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;
`ifdef RX_PARITY_EN
    logic                 par_bad_reg, par_bad_next;
    logic                 par_pend_reg, par_pend_next;
    logic                 parity_err_reg;
`endif

    // State register and frame datapath
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= WAIT_HIGH;
            cnt_reg        <= '0;
            bidx_reg       <= '0;
            shift_reg      <= '0;
            deliver_reg    <= 1'b0;
            frame_pend_reg <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad_reg    <= 1'b0;
            par_pend_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bidx_reg       <= bidx_next;
            shift_reg      <= shift_next;
            deliver_reg    <= deliver_next;
            frame_pend_reg <= frame_pend_next;
`ifdef RX_PARITY_EN
            par_bad_reg    <= par_bad_next;
            par_pend_reg   <= par_pend_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bidx_next       = bidx_reg;
        shift_next      = shift_reg;
        deliver_next    = 1'b0;
        frame_pend_next = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_next    = par_bad_reg;
        par_pend_next   = 1'b0;
`endif
        case (state_reg)
            WAIT_HIGH: begin
                if (RXC && RXD) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (RXC && !RXD) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (RXC) begin
                    if (cnt_reg == MID_TICK) begin
                        if (RXD) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            cnt_next   = '0;
                            bidx_next  = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            DATA: begin
                if (RXC) begin
                    if (cnt_reg == END_TICK) begin
                        shift_next[bidx_reg] = RXD;
                        cnt_next             = '0;
                        if (bidx_reg == LAST_BIT) begin
`ifdef RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bidx_next = bidx_reg + BW'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (RXC) begin
                    if (cnt_reg == END_TICK) begin
                        // Expected bit is XOR of data (inverted for odd); bad when sample differs.
                        par_bad_next = RXD ^ (^shift_reg) ^ PARITY_ODD;
                        cnt_next     = '0;
                        state_next   = STOP;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (RXC) begin
                    if (cnt_reg == END_TICK) begin
                        cnt_next = '0;
                        if (RXD) begin
                            state_next = IDLE;
`ifdef RX_PARITY_EN
                            if (par_bad_reg) begin
                                par_pend_next = 1'b1;
                            end else begin
                                deliver_next = 1'b1;
                            end
`else
                            deliver_next = 1'b1;
`endif
                        end else begin
                            // Framing error wins over parity; wait for the line to recover.
                            frame_pend_next = 1'b1;
                            state_next      = WAIT_HIGH;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = WAIT_HIGH;
            end
        endcase
    end

    // Host-side handshake and status pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg <= frame_pend_reg;
            overrun_reg   <= deliver_reg && valid_reg && !DATA_READY;
`ifdef RX_PARITY_EN
            parity_err_reg <= par_pend_reg;
`endif
            if (deliver_reg && (!valid_reg || DATA_READY)) begin
                data_out_reg <= shift_reg;
                valid_reg    <= 1'b1;
            end else if (valid_reg && DATA_READY) begin
                valid_reg <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        BUSY       = (state_reg != WAIT_HIGH) && (state_reg != IDLE);
        DATA_OUT   = data_out_reg;
        DATA_VALID = valid_reg;
        FRAME_ERR  = frame_err_reg;
        OVERRUN    = overrun_reg;
`ifdef RX_PARITY_EN
        PARITY_ERR = parity_err_reg;
`endif
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected events, monitor pops on DUT outputs.
module tb_uart_rx_ctrl;

    localparam int DB = 8;
    localparam int OS = 16;
`ifdef RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    localparam int EV_NONE = 0;
    localparam int EV_DATA = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;
    localparam int EV_PERR = 4;

    typedef struct {
        int          kind;
        logic [DB-1:0] data;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          RST;
    logic          RXC;
    logic          RXD;
    logic          DATA_READY;
    logic [DB-1:0] DATA_OUT;
    logic          DATA_VALID;
    logic          FRAME_ERR;
    logic          OVERRUN;
    logic          BUSY;
`ifdef RX_PARITY_EN
    logic          PARITY_ODD;
    logic          PARITY_ERR;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .CLK        (clk),
        .RST        (RST),
        .RXC        (RXC),
        .RXD        (RXD),
        .DATA_READY (DATA_READY),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
`ifdef RX_PARITY_EN
        ,
        .PARITY_ODD (PARITY_ODD),
        .PARITY_ERR (PARITY_ERR)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    // One RXC tick; optionally registers an expected event and changes DATA_READY mid-tick.
    task automatic tick(input logic v, input int kind, input logic [DB-1:0] d, input int rdy_set);
        exp_t e;
        @(negedge clk);
        RXD = v;
        RXC = 1'b1;
        if (kind != EV_NONE) begin
            e.kind = kind;
            e.data = d;
            e.cyc  = cyc + 2;
            q.push_back(e);
        end
        @(negedge clk);
        RXC = 1'b0;
        if (rdy_set >= 0) DATA_READY = rdy_set[0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, EV_NONE, '0, -1);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit,
                              input int kind, input logic [DB-1:0] exp_d, input int rdy_set);
        int   stop_idx;
        int   b;
        logic v;
        stop_idx = OS / 2 + (1 + DB + P) * OS;
        $display("send frame data=%h stop=%0d par=%0d", d, stop_bit, par_bit);
        for (int t = 0; t < (2 + DB + P) * OS; t++) begin
            b = t / OS;
            if (b == 0)            v = 1'b0;
            else if (b <= DB)      v = d[b-1];
            else if (b == DB + P)  v = par_bit;
            else                   v = stop_bit;
            if (t == stop_idx) tick(v, kind, exp_d, rdy_set);
            else               tick(v, EV_NONE, '0, -1);
        end
    endtask

    task automatic got(input int kind);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d cyc=%0d data=%h, required none", kind, cyc, DATA_OUT);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_kind_time: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                         kind, cyc, e.kind, e.cyc);
            end else begin
                $display("event kind=%0d cyc=%0d data=%h", kind, cyc, DATA_OUT);
            end
            if (kind == EV_DATA || kind == EV_OVR) begin
                checks++;
                if (DATA_OUT !== e.data) begin
                    errors++;
                    $display("FAIL event_data: got %h expected %h", DATA_OUT, e.data);
                end
            end
        end
    endtask

    // Monitor: sample #1 after each rising edge; a delivery is a fresh or refilled DATA_VALID.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (RST) begin
                prev_valid = 1'b0;
            end else begin
                if (DATA_VALID && (!prev_valid || DATA_READY)) got(EV_DATA);
                if (FRAME_ERR) got(EV_FERR);
                if (OVERRUN) got(EV_OVR);
`ifdef RX_PARITY_EN
                if (PARITY_ERR) got(EV_PERR);
`endif
                prev_valid = DATA_VALID;
            end
        end
    end

    initial begin
        RST = 1'b1;
        RXC = 1'b0;
        RXD = 1'b1;
        DATA_READY = 1'b1;
`ifdef RX_PARITY_EN
        PARITY_ODD = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(DATA_OUT), 32'h0);
        chk("rst_valid", 32'(DATA_VALID), 32'h0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        chk("rst_overrun", 32'(OVERRUN), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        RST = 1'b0;
        idle(4);

        // Basic frame
        send_frame(8'hA5, 1'b1, ^8'hA5, EV_DATA, 8'hA5, -1);
        idle(4);

        // False start: 4 low ticks then high
        for (int i = 0; i < 4; i++) tick(1'b0, EV_NONE, '0, -1);
        chk("false_start_busy", 32'(BUSY), 32'h1);
        idle(12);
        chk("false_start_idle", 32'(BUSY), 32'h0);
        send_frame(8'h3C, 1'b1, ^8'h3C, EV_DATA, 8'h3C, -1);
        idle(4);

        // Framing error, then line stuck low
        send_frame(8'h3C, 1'b0, ^8'h3C, EV_FERR, '0, -1);
        for (int i = 0; i < 40; i++) tick(1'b0, EV_NONE, '0, -1);
        chk("stuck_low_busy", 32'(BUSY), 32'h0);
        idle(1);
        send_frame(8'h96, 1'b1, ^8'h96, EV_DATA, 8'h96, -1);
        idle(4);

        // Overrun, then delivery coinciding with consumption
        DATA_READY = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, EV_DATA, 8'h11, -1);
        idle(4);
        send_frame(8'h22, 1'b1, ^8'h22, EV_OVR, 8'h11, -1);
        idle(4);
        send_frame(8'h33, 1'b1, ^8'h33, EV_DATA, 8'h33, 1);
        idle(4);
        chk("consumed_valid", 32'(DATA_VALID), 32'h0);

        // Asynchronous reset in the middle of a frame
        DATA_READY = 1'b0;
        send_frame(8'h0F, 1'b1, ^8'h0F, EV_DATA, 8'h0F, -1);
        idle(2);
        for (int i = 0; i < OS; i++) tick(1'b0, EV_NONE, '0, -1);
        for (int i = 0; i < 4 * OS + OS / 2; i++) tick(1'b1, EV_NONE, '0, -1);
        chk("pre_rst_busy", 32'(BUSY), 32'h1);
        chk("pre_rst_valid", 32'(DATA_VALID), 32'h1);
        @(negedge clk);
        #1 RST = 1'b1;
        #1;
        chk("async_rst_data_out", 32'(DATA_OUT), 32'h0);
        chk("async_rst_valid", 32'(DATA_VALID), 32'h0);
        chk("async_rst_busy", 32'(BUSY), 32'h0);
        chk("async_rst_flags", 32'({FRAME_ERR, OVERRUN}), 32'h0);
        repeat (2) @(negedge clk);
        RST = 1'b0;
        idle(4);
        DATA_READY = 1'b1;
        send_frame(8'h5A, 1'b1, ^8'h5A, EV_DATA, 8'h5A, -1);
        idle(4);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, EV_DATA, 8'h07, -1);
        idle(4);
        send_frame(8'h07, 1'b1, 1'b0, EV_PERR, '0, -1);
        idle(4);
        send_frame(8'h07, 1'b0, 1'b0, EV_FERR, '0, -1);
        idle(4);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
